instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Consumes the 24-bit program counter value and fetches one instruction word per PC from instruction memory over a valid/ready request and valid response interface.
- Drives the PC's pc_control (00 hold, 01 increment) so the PC advances exactly once per accepted memory request.
- Buffers fetched instructions, each tagged with its PC, in a small queue.
- Presents them to decode over a valid/ready interface. Sits between the program counter and the decode stage.

Parameters:
- ADDR_WIDTH, 24, PC / memory address width.
- INSTR_WIDTH, 32, instruction word width.
- QUEUE_DEPTH, 2, instruction queue entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_in  input  ADDR_WIDTH  current PC value.
- pc_control  output  2  00 hold, 01 increment; 10 and 11 never driven.
- stall  input  1  inhibits new fetch requests.
- mem_req_valid  output  1  read request valid.
- mem_req_addr  output  ADDR_WIDTH  read address.
- mem_req_ready  input  1  memory accepts request.
- mem_rsp_valid  input  1  read data valid.
- mem_rsp_data  input  INSTR_WIDTH  read data.
- instr_valid  output  1  queue head valid.
- instr_data  output  INSTR_WIDTH  queue head instruction.
- instr_pc  output  ADDR_WIDTH  PC of queue head instruction.
- instr_ready  input  1  decode accepts head.

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values: state IDLE, queue empty (count 0, read/write pointers 0), pc_control 00, mem_req_valid 0, instr_valid 0, mem_req_addr 0, instr_data 0, instr_pc 0, captured PC register 0.
- State machine (IDLE, REQ, WAIT); at most one request outstanding:
  - IDLE: go to REQ when stall=0 and count < QUEUE_DEPTH; otherwise stay.
  - REQ: mem_req_valid=1, mem_req_addr=pc_in (combinational).
    - On mem_req_ready=1: capture pc_in into the captured PC register and go to WAIT.
    - While ready=0: stay in REQ holding valid high. stall does not withdraw a presented request.
  - WAIT: wait for mem_rsp_valid=1, then push {captured PC, mem_rsp_data} into the queue.
    - Next state is REQ if stall=0 and (count + 1 − pop) < QUEUE_DEPTH, else IDLE.
- pc_control:
  - Combinational: 01 exactly in cycles where state=REQ and mem_req_ready=1; 00 in all other cycles.
  - The PC therefore presents the next address in the cycle after acceptance.
- Response rules:
  - mem_rsp_valid is ignored outside WAIT (spurious or post-reset responses are dropped).
  - The earliest legal response is the cycle after request acceptance.
- Queue:
  - instr_valid = (count != 0); instr_data and instr_pc show the head entry.
  - Pop when instr_valid and instr_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - No bypass: a response becomes visible on instr_valid the cycle after mem_rsp_valid.
  - Overflow is impossible, because a request is only issued with a free slot reserved.
  - Pop when empty is ignored.
  - Pointers wrap modulo QUEUE_DEPTH.
- Latency and throughput:
  - Request-accept to PC increment: 0 cycles (same edge).
  - Response to instr_valid: 1 cycle.
  - With a 1-cycle memory and no backpressure, one instruction is fetched every 2 cycles (REQ, WAIT, REQ, ...).
- Reset mid-operation: immediate return to reset values; any in-flight request is abandoned and its response dropped.

Test Plan:
- Basic fetch: reset, pc_in=0x000010, mem_req_ready=1, 1-cycle memory returns 0xDEADBEEF -> one pc_control=01 pulse during the accept cycle; instr_valid the cycle after the response with instr_pc=0x000010, instr_data=0xDEADBEEF.
- Request backpressure: mem_req_ready low for 3 cycles with pc_in=0x000100 -> mem_req_valid held high and mem_req_addr stable at 0x000100 for 4 cycles; pc_control=01 only in the 4th cycle.
- Queue full: instr_ready=0, continuous fetches from PC 0x000000 -> exactly 2 entries (PCs 0x000000, 0x000001) are fetched, then the block stays in IDLE with pc_control=00. Raising instr_ready pops 0x000000 and a fetch resumes at 0x000002.
- Stall: assert stall in IDLE -> no request and PC held. Assert stall while in REQ with ready=0 -> request stays valid until accepted, then no further request after the response.
- Spurious response and mid-operation reset: mem_rsp_valid in IDLE -> queue count unchanged. Assert reset while in WAIT, then deliver the response -> response dropped, instr_valid=0, state IDLE.
- Simultaneous push and pop: queue holds 1 entry while a response arrives and instr_ready=1 -> count stays 1, the new entry becomes head the next cycle, and order is preserved.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch
// Fetches one instruction word per program-counter value from instruction
// memory and buffers each word, tagged with its PC, in a small queue that
// feeds the decode stage. Only one memory request is outstanding at a time,
// and a request is only issued when a queue slot is free, so the queue can
// never overflow.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   pc_in             current PC value from the program counter
//   pc_control        to the PC: 00 hold, 01 increment (once per accepted request)
//   stall             inhibits new fetch requests
//   mem_req_*         read request to instruction memory (valid/ready, address)
//   mem_rsp_*         read response from instruction memory (valid, data)
//   instr_*           queue head presented to decode (valid/ready, data, PC)
module instruction_fetch #(
    parameter int ADDR_WIDTH  = 24,
    parameter int INSTR_WIDTH = 32,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc_in,
    output logic [1:0]             pc_control,
    input  logic                   stall,
    output logic                   mem_req_valid,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  captured_pc;
    logic [INSTR_WIDTH-1:0] data_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_q   [QUEUE_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;

    logic                   accept;
    logic                   push;
    logic                   pop;
    logic [CNT_W-1:0]       count_after_wait;

    assign accept = (state == REQ) && mem_req_ready;
    assign push   = (state == WAIT) && mem_rsp_valid;
    assign pop    = (count != '0) && instr_ready;

    // Occupancy once the response being accepted this cycle has landed;
    // a head popped in the same cycle frees its slot for the next request.
    assign count_after_wait = count + CNT_W'(1) - CNT_W'(pop);

    // The request is driven straight from the PC so the incremented address
    // appears in the cycle right after acceptance.
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = (state == REQ) ? pc_in : '0;
    assign pc_control    = {1'b0, accept};

    assign instr_valid = (count != '0);
    assign instr_data  = data_q[rd_ptr];
    assign instr_pc    = pc_q[rd_ptr];

    // Fetch sequencer: IDLE waits for a free slot, REQ holds the request
    // until memory accepts it (stall never withdraws it), WAIT waits for the
    // single outstanding response and decides whether to fetch again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            captured_pc <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!stall && (count < DEPTH_C)) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        captured_pc <= pc_in;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        state <= (!stall && (count_after_wait < DEPTH_C)) ? REQ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Circular instruction queue. Responses arriving outside WAIT never
    // reach push, so stale or spurious data is simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                data_q[wr_ptr] <= mem_rsp_data;
                pc_q[wr_ptr]   <= captured_pc;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule
